// File: rtl/arith_adder_multiplier_pkg.sv
// Shared definitions for the execution-stage adder / shift-add multiplier core.
// Holds the default datapath width, the multiplier state encoding and the counter sizing.
package arith_adder_multiplier_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mul_state_t;

    // One extra bit so the iteration counter can represent WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage : arith_adder_multiplier_pkg

// File: rtl/arith_adder_multiplier_adder.sv
// Unsigned WIDTH-bit ripple adder with carry-in and carry-out.
// Used both for the external sum port and for the multiplier accumulator.
module arith_adder_multiplier_adder #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
);

    // Operands are zero-extended so the carry lands in bit WIDTH.
    assign {carry_out, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, carry_in};

endmodule : arith_adder_multiplier_adder

// File: rtl/arith_adder_multiplier.sv
// Integer datapath core: combinational adder plus a WIDTH-cycle shift-add multiplier
// with a rising-level start request and a done/idle status flag.
module arith_adder_multiplier
    import arith_adder_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    input  logic             start_mul,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] mul_result,
    output logic             mul_done
);

    localparam int                CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    mul_state_t       state;
    mul_state_t       state_next;
    logic             start_hist;
    logic             accept;
    logic             last_iter;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] partial;
    logic [WIDTH-1:0] acc_sum;
    logic             acc_carry_unused;

    // External adder port.
    arith_adder_multiplier_adder #(.WIDTH(WIDTH)) u_sum_adder (
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .sum       (sum),
        .carry_out (carry_out)
    );

    // Accumulator adder: only the low word of the product is kept, so its carry is dropped.
    assign partial = mcand_q & {WIDTH{mplier_q[0]}};

    arith_adder_multiplier_adder #(.WIDTH(WIDTH)) u_acc_adder (
        .a         (acc_q),
        .b         (partial),
        .carry_in  (1'b0),
        .sum       (acc_sum),
        .carry_out (acc_carry_unused)
    );

    // A request is taken only on a rising level while idle; a held start never restarts.
    assign accept    = (state == IDLE) && start_mul && !start_hist;
    assign last_iter = (state == BUSY) && (cnt_q == LAST_CNT);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state always uses non-blocking assignment so every
            // register samples pre-edge values regardless of block ordering.
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: assign a default before any branch so no path leaves the
        // variable unassigned, which would infer a latch.
        state_next = state;
        unique case (state)
            IDLE: if (accept)    state_next = BUSY;
            BUSY: if (last_iter) state_next = IDLE;
            default:             state_next = IDLE;
        endcase
    end

    // Output logic: done is simply "not busy", so it falls at the accept edge
    // and rises at the completion edge, and reset forces it high at once.
    always_comb begin
        mul_done = (state == IDLE);
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath is reset too because mul_result must read 0 after
            // reset and an aborted multiply must not leak stale partial products.
            start_hist <= 1'b0;
            cnt_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            mul_result <= '0;
        end else begin
            start_hist <= start_mul;
            if (accept) begin
                mcand_q  <= multiplicand;
                mplier_q <= multiplier;
                acc_q    <= '0;
                cnt_q    <= '0;
            end else if (state == BUSY) begin
                acc_q    <= acc_sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
                cnt_q    <= cnt_q + CNT_ONE;
                // The final iteration's partial product is folded in on the same edge.
                if (last_iter) begin
                    mul_result <= acc_sum;
                end
            end
        end
    end

endmodule : arith_adder_multiplier

// File: tb/tb_arith_adder_multiplier.sv
// Self-checking bench for arith_adder_multiplier: table-driven adder and multiply
// vectors, hand-written handshake/abort sequences, and randomized traffic vs a model.
module tb_arith_adder_multiplier;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         start_mul;
    logic [W-1:0] multiplicand;
    logic [W-1:0] multiplier;
    logic [W-1:0] mul_result;
    logic         mul_done;

    int n_pass  = 0;
    int n_total = 0;

    arith_adder_multiplier #(.WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .a            (a),
        .b            (b),
        .carry_in     (carry_in),
        .sum          (sum),
        .carry_out    (carry_out),
        .start_mul    (start_mul),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .mul_result   (mul_result),
        .mul_done     (mul_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string        name;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } add_vec_t;

    typedef struct {
        string        name;
        logic [W-1:0] mc;
        logic [W-1:0] mp;
        logic [W-1:0] prod;
    } mul_vec_t;

    add_vec_t avec[6];
    mul_vec_t mvec[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: low word of the full-precision unsigned product.
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [2*W-1:0] p;
        p = (2*W)'(x) * (2*W)'(y);
        return p[W-1:0];
    endfunction

    // One complete multiply with exact latency checks. noisy scrambles operands and
    // start while busy; late_start raises start so it lands on the completion edge.
    task automatic do_mul(input string name, input logic [W-1:0] mc, input logic [W-1:0] mp,
                          input logic [W-1:0] exp, input bit noisy, input bit late_start);
        start_mul = 1'b0;
        tick();
        multiplicand = mc;
        multiplier   = mp;
        start_mul    = 1'b1;
        tick();                                   // edge N
        check({name, "_busy_at_N"}, 64'(mul_done), 64'(0));
        start_mul = 1'b0;
        for (int i = 1; i < W; i++) begin
            if (noisy) begin
                multiplicand = $urandom;
                multiplier   = $urandom;
                start_mul    = 1'($urandom_range(0, 1));
            end
            tick();
        end                                       // now at N+31
        check({name, "_busy_at_N+31"}, 64'(mul_done), 64'(0));
        start_mul = late_start;
        tick();                                   // edge N+32
        check({name, "_done_at_N+32"}, 64'(mul_done), 64'(1));
        check({name, "_result"}, 64'(mul_result), 64'(exp));
        if (late_start) begin
            for (int i = 0; i < 4; i++) tick();
            check({name, "_no_restart_done"}, 64'(mul_done), 64'(1));
            check({name, "_no_restart_result"}, 64'(mul_result), 64'(exp));
        end
        start_mul = 1'b0;
    endtask

    initial begin
        int busy_cycles;
        logic [W:0] full;

        avec[0] = '{"add_5_7",        32'd5,          32'd7,          1'b0, 32'd12,         1'b0};
        avec[1] = '{"add_wrap",       32'hFFFF_FFFF,  32'd1,          1'b0, 32'd0,          1'b1};
        avec[2] = '{"add_cin_only",   32'd0,          32'd0,          1'b1, 32'd1,          1'b0};
        avec[3] = '{"add_all_ones",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, 32'hFFFF_FFFF,  1'b1};
        avec[4] = '{"add_msb_pair",   32'h8000_0000,  32'h8000_0000,  1'b0, 32'd0,          1'b1};
        avec[5] = '{"add_no_carry",   32'h1234_5678,  32'h1111_1111,  1'b0, 32'h2345_6789,  1'b0};

        mvec[0] = '{"mul_6x7",        32'd6,          32'd7,          32'd42};
        mvec[1] = '{"mul_wrap_64k",   32'h0001_0000,  32'h0001_0000,  32'd0};
        mvec[2] = '{"mul_neg1x2",     32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFE};
        mvec[3] = '{"mul_zero",       32'd0,          32'hFFFF_FFFF,  32'd0};
        mvec[4] = '{"mul_neg1xneg1",  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1};
        mvec[5] = '{"mul_3x3",        32'd3,          32'd3,          32'd9};

        rst_n = 1'b0; a = '0; b = '0; carry_in = 1'b0;
        start_mul = 1'b0; multiplicand = '0; multiplier = '0;
        #2;
        check("reset_done", 64'(mul_done), 64'(1));
        check("reset_result", 64'(mul_result), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();

        // Adder table and random adder traffic.
        foreach (avec[i]) begin
            a = avec[i].a; b = avec[i].b; carry_in = avec[i].cin;
            #1;
            check({avec[i].name, "_sum"}, 64'(sum), 64'(avec[i].sum));
            check({avec[i].name, "_cout"}, 64'(carry_out), 64'(avec[i].cout));
        end
        for (int i = 0; i < 16; i++) begin
            a = $urandom; b = $urandom; carry_in = 1'($urandom_range(0, 1));
            full = {1'b0, a} + {1'b0, b} + (W+1)'(carry_in);
            #1;
            check("add_random", 64'({carry_out, sum}), 64'(full));
        end

        // Multiply table.
        foreach (mvec[i]) do_mul(mvec[i].name, mvec[i].mc, mvec[i].mp, mvec[i].prod, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears a non-zero result at once.
        do_mul("mul_pre_reset", 32'd6, 32'd7, 32'd42, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        check("async_reset_done", 64'(mul_done), 64'(1));
        check("async_reset_result", 64'(mul_result), 64'(0));
        #2 rst_n = 1'b1;
        tick();

        // Held start: exactly one multiply in 100 cycles.
        multiplicand = 32'd5; multiplier = 32'd9; start_mul = 1'b1;
        busy_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (!mul_done) busy_cycles++;
        end
        check("held_start_busy_cycles", 64'(busy_cycles), 64'(W));
        check("held_start_done", 64'(mul_done), 64'(1));
        check("held_start_result", 64'(mul_result), 64'(45));
        // Dropping then raising start runs a second multiply.
        do_mul("held_start_second", 32'd11, 32'd13, 32'd143, 1'b0, 1'b0);

        // Abort at N+10, then a fresh multiply.
        start_mul = 1'b0; tick();
        multiplicand = 32'd1234; multiplier = 32'd5678; start_mul = 1'b1;
        tick();
        start_mul = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("abort_busy_before", 64'(mul_done), 64'(0));
        #3 rst_n = 1'b0;
        #1;
        check("abort_done", 64'(mul_done), 64'(1));
        check("abort_result", 64'(mul_result), 64'(0));
        #2 rst_n = 1'b1;
        tick();
        do_mul("after_abort_3x3", 32'd3, 32'd3, 32'd9, 1'b0, 1'b0);

        // Start rising on the completion edge is not accepted.
        do_mul("late_start", 32'd100, 32'd200, 32'd20000, 1'b0, 1'b1);

        // Randomized multiplies with operand/start noise while busy.
        for (int i = 0; i < 12; i++) begin
            logic [W-1:0] x, y;
            x = $urandom; y = $urandom;
            if (i == 0) y = 32'h8000_0000;
            do_mul("mul_random", x, y, ref_mul(x, y), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_arith_adder_multiplier
